// File: rtl/qspi_page_writer.sv
// qspi_page_writer: streams a payload into 256-byte page buffers and writes each page to QSPI
// flash through qspi_mem_controller: optional 64 KiB sector erase, then WREN / PP / RDSR polling.
// Ports:
//   CLK_100M, RESET_N          clock, synchronous active-low reset
//   start, base_addr, erase_en job request (base_addr[7:0] ignored)
//   s_data/s_valid/s_last/s_ready  payload stream
//   mc_*                       controller command interface
//   busy, done, err, pages_written job status
module qspi_page_writer #(
  parameter int unsigned POLL_LIMIT = 32'd1 << 20
) (
  input  logic          CLK_100M,
  input  logic          RESET_N,
  input  logic          start,
  input  logic [23:0]   base_addr,
  input  logic          erase_en,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  input  logic          s_last,
  output logic          s_ready,
  output logic          mc_trigger,
  output logic [7:0]    mc_cmd,
  output logic [23:0]   mc_addr,
  output logic [2047:0] mc_data_send,
  input  logic [7:0]    mc_readout,
  input  logic          mc_busy,
  input  logic          mc_error,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [15:0]   pages_written
);

  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_SE   = 8'hD8;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  typedef enum logic [2:0] {
    StIdle, StFill, StWren, StErase, StProg, StPoll, StNext, StFinish
  } state_e;

  state_e          state_q, state_d;
  logic [23:0]     addr_q, addr_d;
  logic            erase_en_q, erase_en_d;
  logic            first_q, first_d;        // current page is the first of the job
  logic            erased_q, erased_d;      // sector erase already done for this page
  logic            programmed_q, programmed_d; // PP done; next POLL end moves to NEXT
  logic            last_q, last_d;          // s_last seen in this job
  logic            issued_q, issued_d;      // command in flight, waiting for mc_busy=0
  logic [7:0]      idx_q, idx_d;
  logic [2047:0]   buf_q, buf_d;
  logic [31:0]     poll_cnt_q, poll_cnt_d;
  logic            err_q, err_d;
  logic [15:0]     pages_q, pages_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [23:0]     cmd_addr_q, cmd_addr_d;

  logic [7:0]      issue_cmd;
  logic [23:0]     issue_addr;
  logic            cmd_state, cmd_complete, need_erase;

  logic unused_inputs;
  assign unused_inputs = ^{mc_readout[7:1], base_addr[7:0]};

  assign need_erase = erase_en_q & (first_q | (addr_q[15:0] == 16'h0000)) & ~erased_q;

  always_comb begin
    issue_cmd  = CMD_RDSR;
    issue_addr = addr_q;
    cmd_state  = 1'b1;
    unique case (state_q)
      StWren:  issue_cmd = CMD_WREN;
      StErase: begin
        issue_cmd  = CMD_SE;
        issue_addr = {addr_q[23:16], 16'h0000};
      end
      StProg:  issue_cmd = CMD_PP;
      StPoll:  issue_cmd = CMD_RDSR;
      default: cmd_state = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    erase_en_d   = erase_en_q;
    first_d      = first_q;
    erased_d     = erased_q;
    programmed_d = programmed_q;
    last_d       = last_q;
    issued_d     = issued_q;
    idx_d        = idx_q;
    buf_d        = buf_q;
    poll_cnt_d   = poll_cnt_q;
    err_d        = err_q;
    pages_d      = pages_q;
    cmd_d        = cmd_q;
    cmd_addr_d   = cmd_addr_q;
    s_ready      = 1'b0;
    mc_trigger   = 1'b0;
    cmd_complete = 1'b0;

    // Shared handshake: trigger only while the controller is idle, then wait for mc_busy=0
    // starting the cycle after the trigger.
    if (cmd_state) begin
      if (!issued_q) begin
        if (!mc_busy) begin
          mc_trigger = 1'b1;
          issued_d   = 1'b1;
          cmd_d      = issue_cmd;
          cmd_addr_d = issue_addr;
          if (state_q == StPoll) poll_cnt_d = poll_cnt_q + 32'd1;
        end
      end else if (!mc_busy) begin
        issued_d     = 1'b0;
        cmd_complete = 1'b1;
      end
    end

    if (cmd_complete && mc_error) begin
      err_d   = 1'b1;
      state_d = StFinish;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            addr_d       = {base_addr[23:8], 8'h00};
            erase_en_d   = erase_en;
            err_d        = 1'b0;
            pages_d      = 16'd0;
            first_d      = 1'b1;
            erased_d     = 1'b0;
            programmed_d = 1'b0;
            last_d       = 1'b0;
            issued_d     = 1'b0;
            idx_d        = 8'd0;
            buf_d        = '1;
            state_d      = StFill;
          end
        end
        StFill: begin
          s_ready = 1'b1;
          if (s_valid) begin
            buf_d[{idx_q, 3'b000} +: 8] = s_data;
            idx_d = idx_q + 8'd1;
            if (s_last) last_d = 1'b1;
            if (s_last || idx_q == 8'hFF) state_d = StWren;
          end
        end
        StWren: if (cmd_complete) state_d = need_erase ? StErase : StProg;
        StErase: begin
          if (cmd_complete) begin
            erased_d   = 1'b1;
            poll_cnt_d = 32'd0;
            state_d    = StPoll;
          end
        end
        StProg: begin
          if (cmd_complete) begin
            programmed_d = 1'b1;
            poll_cnt_d   = 32'd0;
            state_d      = StPoll;
          end
        end
        StPoll: begin
          if (cmd_complete) begin
            if (!mc_readout[0]) begin
              state_d = programmed_q ? StNext : StWren;
            end else if (poll_cnt_q >= POLL_LIMIT) begin
              err_d   = 1'b1;
              state_d = StFinish;
            end
          end
        end
        StNext: begin
          pages_d      = pages_q + 16'd1;
          addr_d       = addr_q + 24'h000100;
          first_d      = 1'b0;
          erased_d     = 1'b0;
          programmed_d = 1'b0;
          idx_d        = 8'd0;
          buf_d        = '1;
          state_d      = last_q ? StFinish : StFill;
        end
        StFinish: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK_100M) begin
    if (!RESET_N) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      erase_en_q   <= 1'b0;
      first_q      <= 1'b0;
      erased_q     <= 1'b0;
      programmed_q <= 1'b0;
      last_q       <= 1'b0;
      issued_q     <= 1'b0;
      idx_q        <= '0;
      buf_q        <= '1;
      poll_cnt_q   <= '0;
      err_q        <= 1'b0;
      pages_q      <= '0;
      cmd_q        <= '0;
      cmd_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      erase_en_q   <= erase_en_d;
      first_q      <= first_d;
      erased_q     <= erased_d;
      programmed_q <= programmed_d;
      last_q       <= last_d;
      issued_q     <= issued_d;
      idx_q        <= idx_d;
      buf_q        <= buf_d;
      poll_cnt_q   <= poll_cnt_d;
      err_q        <= err_d;
      pages_q      <= pages_d;
      cmd_q        <= cmd_d;
      cmd_addr_q   <= cmd_addr_d;
    end
  end

  // Command fields are live in the trigger cycle and held afterwards.
  assign mc_cmd        = mc_trigger ? issue_cmd  : cmd_q;
  assign mc_addr       = mc_trigger ? issue_addr : cmd_addr_q;
  assign mc_data_send  = buf_q;
  assign busy          = (state_q != StIdle) && (state_q != StFinish);
  assign done          = (state_q == StFinish);
  assign err           = err_q;
  assign pages_written = pages_q;

endmodule

// File: tb/tb_qspi_page_writer.sv
module tb_qspi_page_writer;

  logic          CLK_100M = 1'b0;
  logic          RESET_N = 1'b0;
  logic          start = 1'b0;
  logic [23:0]   base_addr = '0;
  logic          erase_en = 1'b0;
  logic [7:0]    s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic          mc_trigger;
  logic [7:0]    mc_cmd;
  logic [23:0]   mc_addr;
  logic [2047:0] mc_data_send;
  logic [7:0]    mc_readout = '0;
  logic          mc_busy = 1'b0;
  logic          mc_error = 1'b0;
  logic          busy, done, err;
  logic [15:0]   pages_written;

  int checks = 0;
  int passes = 0;

  // Controller model state
  logic [7:0]    log_cmd[$];
  logic [23:0]   pp_addr[$];
  logic [23:0]   se_addr[$];
  logic [2047:0] pp_data[$];
  int            bcnt = 0;
  int            streak = 0;
  int            trig_viol = 0;
  logic          wip_forever = 1'b0;
  logic          pp_err = 1'b0;

  qspi_page_writer #(.POLL_LIMIT(8)) dut (
    .CLK_100M(CLK_100M), .RESET_N(RESET_N), .start(start), .base_addr(base_addr),
    .erase_en(erase_en), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .mc_trigger(mc_trigger), .mc_cmd(mc_cmd), .mc_addr(mc_addr),
    .mc_data_send(mc_data_send), .mc_readout(mc_readout), .mc_busy(mc_busy),
    .mc_error(mc_error), .busy(busy), .done(done), .err(err), .pages_written(pages_written)
  );

  always #5 CLK_100M = ~CLK_100M;

  // Controller: busy for two cycles after the trigger cycle; RDSR reports WIP=1 twice per
  // poll sequence (or forever), PP can be made to fail.
  always @(posedge CLK_100M) begin
    if (mc_trigger) begin
      if (mc_busy) trig_viol <= trig_viol + 1;
      log_cmd.push_back(mc_cmd);
      if (mc_cmd == 8'h02) begin
        pp_addr.push_back(mc_addr);
        pp_data.push_back(mc_data_send);
      end
      if (mc_cmd == 8'hD8) se_addr.push_back(mc_addr);
      mc_busy  <= 1'b1;
      bcnt     <= 2;
      mc_error <= (mc_cmd == 8'h02) && pp_err;
      if (mc_cmd == 8'h05) begin
        streak     <= streak + 1;
        mc_readout <= {7'd0, wip_forever || (streak + 1 <= 2)};
      end else begin
        streak     <= 0;
        mc_readout <= 8'h00;
      end
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) mc_busy <= 1'b0;
    end
  end

  function automatic logic [7:0] pat(input int i);
    pat = 8'((i * 7 + 3) & 255);
  endfunction

  task automatic tick();
    @(posedge CLK_100M);
    #1;
  endtask

  task automatic clear_log();
    log_cmd.delete();
    pp_addr.delete();
    se_addr.delete();
    pp_data.delete();
  endtask

  task automatic do_start(input logic [23:0] a, input logic e);
    start = 1'b1;
    base_addr = a;
    erase_en = e;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    s_data = d;
    s_valid = 1'b1;
    s_last = last;
    while (!s_ready && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 2000) $display("FAIL s_ready_timeout: got s_ready=0 for %0d cycles want 1", n);
    else passes++;
    tick();
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic send_stream(input int count);
    for (int i = 0; i < count; i++) send_byte(pat(i), i == count - 1);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 5000) begin
      tick();
      n++;
    end
    checks++;
    if (!done) $display("FAIL %s_done: got done=0 want 1", name);
    else passes++;
    checks++;
    if (busy !== 1'b0) $display("FAIL %s_busy_at_done: got %b want 0", name, busy);
    else passes++;
    tick();
    checks++;
    if (done !== 1'b0) $display("FAIL %s_done_pulse: got %b want 0 one cycle later", name, done);
    else passes++;
  endtask

  task automatic check_cmds(input string name, input logic [7:0] exp[$]);
    checks++;
    if (log_cmd.size() != exp.size())
      $display("FAIL %s_cmd_count: got %0d want %0d", name, log_cmd.size(), exp.size());
    else passes++;
    for (int i = 0; i < exp.size() && i < log_cmd.size(); i++) begin
      checks++;
      if (log_cmd[i] !== exp[i])
        $display("FAIL %s_cmd[%0d]: got %h want %h", name, i, log_cmd[i], exp[i]);
      else passes++;
    end
  endtask

  task automatic test_reset();
    logic [2047:0] ones;
    ones = '1;
    RESET_N = 1'b0;
    tick();
    tick();
    checks++;
    if ({s_ready, mc_trigger, busy, done, err} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {s_ready, mc_trigger, busy, done, err});
    else passes++;
    checks++;
    if ({pages_written, mc_cmd, mc_addr} !== 48'd0)
      $display("FAIL reset_fields: got %h want 0", {pages_written, mc_cmd, mc_addr});
    else passes++;
    checks++;
    if (mc_data_send !== ones) $display("FAIL reset_data_send: got %h want all 1s", mc_data_send[63:0]);
    else passes++;
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_single_page();
    logic [2047:0] exp;
    clear_log();
    do_start(24'hA30012, 1'b0);
    checks++;
    if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy);
    else passes++;
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b1);
    checks++;
    if (s_ready !== 1'b0) $display("FAIL single_s_ready_drop: got %b want 0", s_ready);
    else passes++;
    do_start(24'h123400, 1'b1);  // must be ignored while busy
    wait_done("single");
    check_cmds("single", '{8'h06, 8'h02, 8'h05, 8'h05, 8'h05});
    exp = '1;
    exp[31:0] = 32'hEFBEADDE;
    checks++;
    if (pp_addr[0] !== 24'hA30000) $display("FAIL single_pp_addr: got %h want A30000", pp_addr[0]);
    else passes++;
    checks++;
    if (pp_data[0] !== exp) $display("FAIL single_pp_data: got %h want %h", pp_data[0][63:0], exp[63:0]);
    else passes++;
    checks++;
    if ({err, pages_written} !== {1'b0, 16'd1})
      $display("FAIL single_status: got err=%b pages=%0d want err=0 pages=1", err, pages_written);
    else passes++;
  endtask

  task automatic test_erase_two_pages();
    logic [2047:0] exp0, exp1;
    clear_log();
    do_start(24'h010000, 1'b1);
    send_stream(300);
    wait_done("erase");
    check_cmds("erase", '{8'h06, 8'hD8, 8'h05, 8'h05, 8'h05, 8'h06, 8'h02, 8'h05, 8'h05, 8'h05,
                          8'h06, 8'h02, 8'h05, 8'h05, 8'h05});
    exp0 = '1;
    exp1 = '1;
    for (int i = 0; i < 256; i++) exp0[i*8 +: 8] = pat(i);
    for (int i = 0; i < 44; i++) exp1[i*8 +: 8] = pat(256 + i);
    checks++;
    if (se_addr[0] !== 24'h010000) $display("FAIL erase_se_addr: got %h want 010000", se_addr[0]);
    else passes++;
    checks++;
    if ({pp_addr[0], pp_addr[1]} !== {24'h010000, 24'h010100})
      $display("FAIL erase_pp_addr: got %h %h want 010000 010100", pp_addr[0], pp_addr[1]);
    else passes++;
    checks++;
    if (pp_data[0] !== exp0) $display("FAIL erase_pp0_data: got %h want %h", pp_data[0][63:0], exp0[63:0]);
    else passes++;
    checks++;
    if (pp_data[1] !== exp1) $display("FAIL erase_pp1_data: got %h want %h", pp_data[1][383:320], exp1[383:320]);
    else passes++;
    checks++;
    if (pages_written !== 16'd2) $display("FAIL erase_pages: got %0d want 2", pages_written);
    else passes++;
  endtask

  task automatic test_addr_wrap();
    clear_log();
    do_start(24'hFFFF00, 1'b0);
    send_stream(512);
    wait_done("wrap");
    checks++;
    if (pp_addr.size() != 2) $display("FAIL wrap_pp_count: got %0d want 2", pp_addr.size());
    else passes++;
    checks++;
    if ({pp_addr[0], pp_addr[1]} !== {24'hFFFF00, 24'h000000})
      $display("FAIL wrap_pp_addr: got %h %h want FFFF00 000000", pp_addr[0], pp_addr[1]);
    else passes++;
    checks++;
    if (pages_written !== 16'd2) $display("FAIL wrap_pages: got %0d want 2", pages_written);
    else passes++;
  endtask

  task automatic test_pp_error();
    clear_log();
    pp_err = 1'b1;
    do_start(24'h000200, 1'b0);
    send_stream(4);
    wait_done("pperr");
    pp_err = 1'b0;
    check_cmds("pperr", '{8'h06, 8'h02});
    checks++;
    if ({err, pages_written} !== {1'b1, 16'd0})
      $display("FAIL pperr_status: got err=%b pages=%0d want err=1 pages=0", err, pages_written);
    else passes++;
    repeat (5) tick();
    checks++;
    if (err !== 1'b1 || log_cmd.size() != 2)
      $display("FAIL pperr_hold: got err=%b cmds=%0d want err=1 cmds=2", err, log_cmd.size());
    else passes++;
  endtask

  task automatic test_poll_timeout();
    clear_log();
    wip_forever = 1'b1;
    do_start(24'h000300, 1'b0);
    send_stream(4);
    wait_done("timeout");
    wip_forever = 1'b0;
    check_cmds("timeout", '{8'h06, 8'h02, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05});
    checks++;
    if ({err, pages_written} !== {1'b1, 16'd0})
      $display("FAIL timeout_status: got err=%b pages=%0d want err=1 pages=0", err, pages_written);
    else passes++;
  endtask

  task automatic test_reset_mid_poll();
    logic [2047:0] ones;
    int n, seen;
    ones = '1;
    clear_log();
    do_start(24'h004400, 1'b0);
    send_stream(4);
    n = 0;
    seen = 0;
    while (seen == 0 && n < 2000) begin
      foreach (log_cmd[i]) if (log_cmd[i] == 8'h05) seen = 1;
      if (seen == 0) tick();
      n++;
    end
    checks++;
    if (seen == 0) $display("FAIL rst_poll_reached: got no RDSR want RDSR");
    else passes++;
    RESET_N = 1'b0;
    tick();
    n = log_cmd.size();
    checks++;
    if ({s_ready, mc_trigger, busy, done, err, pages_written, mc_cmd, mc_addr} !== 53'd0)
      $display("FAIL rst_poll_outputs: got %h want 0",
               {s_ready, mc_trigger, busy, done, err, pages_written, mc_cmd, mc_addr});
    else passes++;
    checks++;
    if (mc_data_send !== ones) $display("FAIL rst_poll_data: got %h want all 1s", mc_data_send[63:0]);
    else passes++;
    RESET_N = 1'b1;
    repeat (6) tick();
    checks++;
    if (log_cmd.size() != n) $display("FAIL rst_poll_no_cmd: got %0d cmds want %0d", log_cmd.size(), n);
    else passes++;
    clear_log();
    do_start(24'h005500, 1'b0);
    send_stream(4);
    wait_done("rst_rerun");
    check_cmds("rst_rerun", '{8'h06, 8'h02, 8'h05, 8'h05, 8'h05});
    checks++;
    if ({err, pages_written, pp_addr[0]} !== {1'b0, 16'd1, 24'h005500})
      $display("FAIL rst_rerun_status: got err=%b pages=%0d addr=%h want 0 1 005500",
               err, pages_written, pp_addr[0]);
    else passes++;
  endtask

  initial begin
    tick();
    test_reset();
    test_single_page();
    test_erase_two_pages();
    test_addr_wrap();
    test_pp_error();
    test_poll_timeout();
    test_reset_mid_poll();
    checks++;
    if (trig_viol != 0) $display("FAIL trigger_while_busy: got %0d want 0", trig_viol);
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
